// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard-unit signal bundle; PIPE_PERF_CNT_EN adds perf counters
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        exe_load;
    logic [4:0]  exe_GPR_waddr;
    logic        mem_req;
    logic        dmem_ready;
    logic        exc_flush;
    logic        pc_ena;
    logic        if_id_ena;
    logic        id_exe_ena;
    logic        exe_mem_ena;
    logic        mem_wb_ena;
    logic        if_id_flush;
    logic        id_exe_bubble;
    logic        exe_mem_flush;
    logic        dmem_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] bubble_cnt;
`endif

    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, exe_load, exe_GPR_waddr,
        input  mem_req, dmem_ready, exc_flush,
        output pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena,
        output if_id_flush, id_exe_bubble, exe_mem_flush, dmem_timeout
`ifdef PIPE_PERF_CNT_EN
        , output stall_cycles, bubble_cnt
`endif
    );

    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, exe_load, exe_GPR_waddr,
        output mem_req, dmem_ready, exc_flush,
        input  pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena,
        input  if_id_flush, id_exe_bubble, exe_mem_flush, dmem_timeout
`ifdef PIPE_PERF_CNT_EN
        , input stall_cycles, bubble_cnt
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer; PIPE_PERF_CNT_EN adds perf counters
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic           clk,
    input  logic           reset,
    pipe_hazard_ctrl_if.master hz
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_C = TIMEOUT_W'(TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] ONE_C     = TIMEOUT_W'(1);

    state_t               state;
    logic [TIMEOUT_W-1:0] wait_cnt;

    logic in_wait, rs_hit, rt_hit, load_use;
    logic do_flush, do_stall, do_timeout, do_bubble, adv;

    always_comb begin
        in_wait    = (state == MEM_WAIT);
        rs_hit     = hz.id_uses_rs && (hz.exe_GPR_waddr == hz.id_rs);
        rt_hit     = hz.id_uses_rt && (hz.exe_GPR_waddr == hz.id_rt);
        load_use   = hz.exe_load && (hz.exe_GPR_waddr != 5'd0) && (rs_hit || rt_hit);
        do_flush   = hz.exc_flush;
        do_timeout = !do_flush && in_wait && !hz.dmem_ready && (wait_cnt == TIMEOUT_C);
        // Once waiting, the access is in flight; only dmem_ready (or watchdog) releases it.
        do_stall   = !do_flush && !do_timeout &&
                     (in_wait ? !hz.dmem_ready : (hz.mem_req && !hz.dmem_ready));
        do_bubble  = !do_flush && !in_wait && !do_stall && load_use;
    end

    // Outputs are forced low for the whole time reset is asserted.
    always_comb begin
        adv               = reset && !do_stall;
        hz.pc_ena         = adv && !do_bubble;
        hz.if_id_ena      = adv && !do_bubble;
        hz.id_exe_ena     = adv;
        hz.exe_mem_ena    = adv;
        hz.mem_wb_ena     = adv;
        hz.if_id_flush    = reset && do_flush;
        hz.id_exe_bubble  = reset && (do_flush || do_bubble);
        hz.exe_mem_flush  = reset && do_flush;
        hz.dmem_timeout   = reset && do_timeout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else if (do_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= (wait_cnt == TIMEOUT_C) ? wait_cnt : wait_cnt + ONE_C;
        end else begin
            state    <= RUN;
            wait_cnt <= '0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hz.stall_cycles <= '0;
            hz.bubble_cnt   <= '0;
        end else begin
            if (do_stall)  hz.stall_cycles <= hz.stall_cycles + 32'd1;
            if (do_bubble) hz.bubble_cnt   <= hz.bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed + random bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   waited = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    localparam logic [8:0] NORMAL  = 9'b11111_000_0;
    localparam logic [8:0] STALL   = 9'b00000_000_0;
    localparam logic [8:0] BUBBLE  = 9'b00111_010_0;
    localparam logic [8:0] FLUSH   = 9'b11111_111_0;
    localparam logic [8:0] TIMEDOUT = 9'b11111_000_1;

    function automatic logic [8:0] observed();
        return {hz.pc_ena, hz.if_id_ena, hz.id_exe_ena, hz.exe_mem_ena, hz.mem_wb_ena,
                hz.if_id_flush, hz.id_exe_bubble, hz.exe_mem_flush, hz.dmem_timeout};
    endfunction

    // Reference: 'waited' is the number of stalled cycles of the access in flight.
    function automatic void model(output logic [8:0] o, output int nw);
        bit hazard;
        hazard = hz.exe_load && hz.exe_GPR_waddr != 0 &&
                 ((hz.id_uses_rs && hz.id_rs == hz.exe_GPR_waddr) ||
                  (hz.id_uses_rt && hz.id_rt == hz.exe_GPR_waddr));
        if (!reset) begin o = STALL; nw = 0; end
        else if (hz.exc_flush) begin o = FLUSH; nw = 0; end
        else if (waited > 0) begin
            if (hz.dmem_ready)     begin o = NORMAL;   nw = 0; end
            else if (waited >= TO) begin o = TIMEDOUT; nw = 0; end
            else                   begin o = STALL;    nw = waited + 1; end
        end
        else if (hz.mem_req && !hz.dmem_ready) begin o = STALL; nw = 1; end
        else if (hazard) begin o = BUBBLE; nw = 0; end
        else begin o = NORMAL; nw = 0; end
    endfunction

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Inputs are already set; check mid-cycle, then advance the model at the edge.
    task automatic cycle(input string tag);
        logic [8:0] exp;
        int nw;
        #3;
        model(exp, nw);
        check(tag, exp);
        @(posedge clk);
        waited = nw;
        #1;
    endtask

    task automatic idle_inputs();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
        hz.exe_load = 1'b0; hz.exe_GPR_waddr = 5'd0;
        hz.mem_req = 1'b0; hz.dmem_ready = 1'b0; hz.exc_flush = 1'b0;
    endtask

    initial begin
        idle_inputs();
        #2 check("reset_outputs", STALL);
        @(posedge clk); #1;
        check("reset_held", STALL);
        reset = 1'b1;
        waited = 0;

        cycle("idle_normal");

        hz.exe_load = 1'b1; hz.exe_GPR_waddr = 5'd5; hz.id_rs = 5'd5; hz.id_uses_rs = 1'b1;
        cycle("lu_bubble");
        hz.exe_load = 1'b0;
        cycle("lu_after");

        hz.exe_load = 1'b1; hz.exe_GPR_waddr = 5'd0; hz.id_rs = 5'd0;
        cycle("r0_no_hazard");
        hz.exe_GPR_waddr = 5'd7; hz.id_rt = 5'd7; hz.id_uses_rt = 1'b0; hz.id_rs = 5'd1;
        cycle("rt_not_used");
        hz.id_uses_rt = 1'b1;
        cycle("rt_hazard");
        idle_inputs();

        hz.mem_req = 1'b1; hz.dmem_ready = 1'b0;
        repeat (3) cycle("mem_wait");
        hz.dmem_ready = 1'b1;
        cycle("mem_release");
        hz.mem_req = 1'b0; hz.dmem_ready = 1'b0;
        cycle("mem_after");

        hz.mem_req = 1'b1; hz.dmem_ready = 1'b1;
        cycle("zero_wait");

        hz.dmem_ready = 1'b0;
        repeat (TO) cycle("to_wait");
        cycle("to_pulse");
        hz.mem_req = 1'b0;
        cycle("to_after");

        hz.mem_req = 1'b1;
        cycle("fl_wait1");
        cycle("fl_wait2");
        hz.exc_flush = 1'b1;
        cycle("fl_flush");
        hz.exc_flush = 1'b0; hz.mem_req = 1'b0;
        cycle("fl_after");

        hz.mem_req = 1'b1;
        cycle("rst_wait1");
        cycle("rst_wait2");
        #3 reset = 1'b0;
        #1 check("rst_async", STALL);
        @(posedge clk); #1;
        check("rst_held", STALL);
        reset = 1'b1;
        waited = 0;
        cycle("rst_new_wait1");
        cycle("rst_new_wait2");
        hz.dmem_ready = 1'b1;
        cycle("rst_new_release");
        idle_inputs();
        cycle("rst_new_after");

        for (int i = 0; i < 600; i++) begin
            hz.id_rs         = 5'($urandom_range(0, 3));
            hz.id_rt         = 5'($urandom_range(0, 3));
            hz.exe_GPR_waddr = 5'($urandom_range(0, 3));
            hz.id_uses_rs    = 1'($urandom_range(0, 1));
            hz.id_uses_rt    = 1'($urandom_range(0, 1));
            hz.exe_load      = 1'($urandom_range(0, 1));
            hz.mem_req       = ($urandom_range(0, 3) == 0);
            hz.dmem_ready    = ($urandom_range(0, 4) == 0);
            hz.exc_flush     = ($urandom_range(0, 19) == 0);
            cycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
